// File: rtl/div_arbiter_if.sv
// Bundle of request, response and divider-side signals for div_arbiter.
// slave is the arbiter's view; master is the requesters-plus-divider view.
interface div_arbiter_if #(
    parameter int XLEN = 64
);
    logic            ReqValid0, ReqValid1;
    logic            ReqReady0, ReqReady1;
    logic [XLEN-1:0] ReqSrcA0, ReqSrcA1;
    logic [XLEN-1:0] ReqSrcB0, ReqSrcB1;
    logic            ReqSigned0, ReqSigned1;
    logic            ReqW640, ReqW641;
    logic            ReqRem0, ReqRem1;
    logic            Flush0, Flush1;

    logic            RspValid;
    logic            RspReady;
    logic            RspId;
    logic [XLEN-1:0] RspData;

    logic            DivStart;
    logic [XLEN-1:0] DivSrcA, DivSrcB;
    logic            DivSigned, DivW64;
    logic            DivDone;
    logic [XLEN-1:0] DivQuot, DivRem;

    modport slave (
        input  ReqValid0, ReqValid1, ReqSrcA0, ReqSrcA1, ReqSrcB0, ReqSrcB1,
               ReqSigned0, ReqSigned1, ReqW640, ReqW641, ReqRem0, ReqRem1,
               Flush0, Flush1, RspReady, DivDone, DivQuot, DivRem,
        output ReqReady0, ReqReady1, RspValid, RspId, RspData,
               DivStart, DivSrcA, DivSrcB, DivSigned, DivW64
    );

    modport master (
        output ReqValid0, ReqValid1, ReqSrcA0, ReqSrcA1, ReqSrcB0, ReqSrcB1,
               ReqSigned0, ReqSigned1, ReqW640, ReqW641, ReqRem0, ReqRem1,
               Flush0, Flush1, RspReady, DivDone, DivQuot, DivRem,
        input  ReqReady0, ReqReady1, RspValid, RspId, RspData,
               DivStart, DivSrcA, DivSrcB, DivSigned, DivW64
    );
endinterface

// File: rtl/div_arbiter.sv
// Two-port arbiter/sequencer sharing one iterative divider, with flush draining.
// Optional one-entry result cache enabled by defining DIV_ARBITER_CACHE_EN.
module div_arbiter #(
    parameter int XLEN = 64
) (
    input  logic         clk,
    input  logic         reset,
    div_arbiter_if.slave bus
);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, DRAIN} state_e;

    state_e                     state_q, state_d;
    logic                       prio_q, prio_d;
    logic                       owner_q, owner_d;
    logic [XLEN-1:0]            a_q, a_d, b_q, b_d;
    logic                       sgn_q, sgn_d, w64_q, w64_d, rem_q, rem_d;
    logic [XLEN-1:0]            data_q, data_d;

    logic [1:0]                 req_vld, flush, grant;
    logic [1:0][XLEN-1:0]       src_a, src_b;
    logic [1:0]                 src_sgn, src_w64, src_rem;
    logic                       gsel, g_w64, owner_flush, div_done_acc;
    logic                       hit;
    logic [XLEN-1:0]            hit_data;

    assign src_a   = {bus.ReqSrcA1, bus.ReqSrcA0};
    assign src_b   = {bus.ReqSrcB1, bus.ReqSrcB0};
    assign src_sgn = {bus.ReqSigned1, bus.ReqSigned0};
    assign src_w64 = {bus.ReqW641, bus.ReqW640};
    assign src_rem = {bus.ReqRem1, bus.ReqRem0};
    assign flush   = {bus.Flush1, bus.Flush0};

    // A flush on a port in IDLE hides that port's request for the cycle.
    assign req_vld = {bus.ReqValid1, bus.ReqValid0} & ~flush;

    always_comb begin
        grant = 2'b00;
        if (state_q == IDLE && !reset) begin
            case (req_vld)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = prio_q ? 2'b10 : 2'b01;
                default: grant = 2'b00;
            endcase
        end
    end

    assign gsel          = grant[1];
    assign g_w64         = (XLEN == 64) ? src_w64[gsel] : 1'b0;
    assign owner_flush   = flush[owner_q];
    assign div_done_acc  = bus.DivDone && (state_q == WAIT || state_q == DRAIN);

    assign bus.ReqReady0 = grant[0];
    assign bus.ReqReady1 = grant[1];

`ifdef DIV_ARBITER_CACHE_EN
    logic            c_vld_q;
    logic [XLEN-1:0] c_a_q, c_b_q, c_quot_q, c_rem_q;
    logic            c_sgn_q, c_w64_q;

    assign hit = c_vld_q && (src_a[gsel] == c_a_q) && (src_b[gsel] == c_b_q) &&
                 (src_sgn[gsel] == c_sgn_q) && (g_w64 == c_w64_q);
    assign hit_data = src_rem[gsel] ? c_rem_q : c_quot_q;

    always_ff @(posedge clk) begin
        if (reset) c_vld_q <= 1'b0;
        else if (div_done_acc) c_vld_q <= 1'b1;
    end

    // Drained results are cached too; the operands are still those in a_q/b_q.
    always_ff @(posedge clk) begin
        if (div_done_acc) begin
            c_a_q    <= a_q;
            c_b_q    <= b_q;
            c_sgn_q  <= sgn_q;
            c_w64_q  <= w64_q;
            c_quot_q <= bus.DivQuot;
            c_rem_q  <= bus.DivRem;
        end
    end
`else
    assign hit      = 1'b0;
    assign hit_data = '0;
`endif

    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        owner_d = owner_q;
        a_d     = a_q;
        b_d     = b_q;
        sgn_d   = sgn_q;
        w64_d   = w64_q;
        rem_d   = rem_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (|grant) begin
                    owner_d = gsel;
                    a_d     = src_a[gsel];
                    b_d     = src_b[gsel];
                    sgn_d   = src_sgn[gsel];
                    w64_d   = g_w64;
                    rem_d   = src_rem[gsel];
                    if (&req_vld) prio_d = ~gsel;
                    if (hit) begin
                        data_d  = hit_data;
                        state_d = RESP;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: state_d = owner_flush ? DRAIN : WAIT;
            WAIT: begin
                if (bus.DivDone) begin
                    if (owner_flush) begin
                        state_d = IDLE;
                    end else begin
                        data_d  = rem_q ? bus.DivRem : bus.DivQuot;
                        state_d = RESP;
                    end
                end else if (owner_flush) begin
                    state_d = DRAIN;
                end
            end
            RESP:    if (bus.RspReady || owner_flush) state_d = IDLE;
            DRAIN:   if (bus.DivDone) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            prio_q  <= 1'b0;
            owner_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
            w64_q   <= 1'b0;
            rem_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            owner_q <= owner_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sgn_q   <= sgn_d;
            w64_q   <= w64_d;
            rem_q   <= rem_d;
            data_q  <= data_d;
        end
    end

    assign bus.DivStart  = (state_q == ISSUE);
    assign bus.DivSrcA   = a_q;
    assign bus.DivSrcB   = b_q;
    assign bus.DivSigned = sgn_q;
    assign bus.DivW64    = w64_q;
    assign bus.RspValid  = (state_q == RESP);
    assign bus.RspId     = owner_q;
    assign bus.RspData   = data_q;
endmodule

// File: tb/tb_div_arbiter.sv
// Scoreboard bench for div_arbiter with a fixed-latency behavioural divider.
`timescale 1ns/1ps
module tb_div_arbiter;
    localparam int XLEN = 64;
    localparam int N    = 4;
`ifdef DIV_ARBITER_CACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif

    typedef struct packed {
        logic            id;
        logic [XLEN-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    div_arbiter_if #(.XLEN(XLEN)) bus ();
    div_arbiter #(.XLEN(XLEN)) dut (.clk(clk), .reset(reset), .bus(bus));

    int   checks = 0, failures = 0;
    int   cyc = 0, start_cnt = 0, last_start = -1;
    exp_t sb[$];
    exp_t e;

    always @(posedge clk) cyc <= cyc + 1;

    // Divider stand-in: DivDone arrives N cycles after the DivStart cycle.
    logic            d_busy;
    int              d_cnt;
    logic [XLEN-1:0] d_a, d_b;
    logic            d_sgn;

    function automatic logic [2*XLEN-1:0] ref_div(input logic [XLEN-1:0] a, b, input logic s);
        logic [XLEN-1:0] q, r;
        if (b == '0) begin
            q = '1;
            r = a;
        end else if (s) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {q, r};
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            d_busy <= 1'b0;
            d_cnt  <= 0;
        end else if (bus.DivStart) begin
            d_busy <= 1'b1;
            d_cnt  <= N - 1;
            d_a    <= bus.DivSrcA;
            d_b    <= bus.DivSrcB;
            d_sgn  <= bus.DivSigned;
        end else if (d_busy) begin
            if (d_cnt == 0) d_busy <= 1'b0;
            else d_cnt <= d_cnt - 1;
        end
    end
    assign bus.DivDone = d_busy && (d_cnt == 0);
    assign {bus.DivQuot, bus.DivRem} = ref_div(d_a, d_b, d_sgn);

    task automatic chk(input string nm, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always begin
        @(negedge clk);
        if (!reset) begin
            if (bus.DivStart) begin
                start_cnt++;
                last_start = cyc;
            end
            if (bus.RspValid && bus.RspReady) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_rsp: got id=%0d data=%0h expected no response", bus.RspId, bus.RspData);
                end else begin
                    e = sb.pop_front();
                    chk("rsp_id", XLEN'(bus.RspId), XLEN'(e.id));
                    chk("rsp_data", bus.RspData, e.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic id, input logic [XLEN-1:0] d);
        sb.push_back('{id: id, data: d});
    endtask

    task automatic set_req(input int p, input logic v, input logic [XLEN-1:0] a, b, input logic s, r);
        if (p == 0) begin
            bus.ReqValid0 = v; bus.ReqSrcA0 = a; bus.ReqSrcB0 = b; bus.ReqSigned0 = s; bus.ReqRem0 = r;
        end else begin
            bus.ReqValid1 = v; bus.ReqSrcA1 = a; bus.ReqSrcB1 = b; bus.ReqSigned1 = s; bus.ReqRem1 = r;
        end
    endtask

    task automatic wait_grant(input int p, output int t);
        bit got = 1'b0;
        t = -1;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if ((p == 0 && bus.ReqReady0) || (p == 1 && bus.ReqReady1)) begin
                got = 1'b1;
                t = cyc;
            end
        end
        chk("grant_seen", XLEN'(got), 1);
    endtask

    task automatic wait_grant_any(output int g, output int t);
        bit got = 1'b0;
        g = -1;
        t = -1;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (bus.ReqReady0 || bus.ReqReady1) begin
                got = 1'b1;
                t = cyc;
                g = bus.ReqReady1 ? 1 : 0;
                chk("ready_onehot", XLEN'(bus.ReqReady0 & bus.ReqReady1), 0);
            end
        end
        chk("grant_any_seen", XLEN'(got), 1);
    endtask

    task automatic wait_rsp(output int r);
        bit got = 1'b0;
        r = -1;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (bus.RspValid) begin
                got = 1'b1;
                r = cyc;
            end
        end
        chk("rsp_seen", XLEN'(got), 1);
    endtask

    task automatic wait_sb_empty();
        for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
        chk("sb_empty", XLEN'(sb.size()), 0);
        tick();
    endtask

    initial begin
        int t, r, g, s0, fc;
        reset = 1'b1;
        bus.RspReady = 1'b1;
        bus.Flush0 = 1'b0; bus.Flush1 = 1'b0;
        bus.ReqW640 = 1'b0; bus.ReqW641 = 1'b0;
        set_req(0, 1'b1, 64'd5, 64'd1, 1'b0, 1'b0);
        set_req(1, 1'b0, '0, '0, 1'b0, 1'b0);

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready0", XLEN'(bus.ReqReady0), 0);
        chk("rst_ready1", XLEN'(bus.ReqReady1), 0);
        chk("rst_rspvalid", XLEN'(bus.RspValid), 0);
        chk("rst_divstart", XLEN'(bus.DivStart), 0);
        tick();
        reset = 1'b0;
        bus.ReqValid0 = 1'b0;
        @(negedge clk);
        chk("rst_srca", bus.DivSrcA, 0);
        chk("rst_srcb", bus.DivSrcB, 0);
        chk("rst_rspdata", bus.RspData, 0);
        tick();

        // Single request, quotient then remainder, with latency checks
        s0 = start_cnt;
        set_req(0, 1'b1, 64'd100, 64'd7, 1'b0, 1'b0);
        wait_grant(0, t);
        push(1'b0, 64'd14);
        tick();
        bus.ReqValid0 = 1'b0;
        wait_rsp(r);
        chk("lat_start", XLEN'(last_start), XLEN'(t + 1));
        chk("lat_rsp", XLEN'(r), XLEN'(t + 2 + N));
        chk("start_pulses", XLEN'(start_cnt - s0), 1);
        wait_sb_empty();

        s0 = start_cnt;
        set_req(0, 1'b1, 64'd100, 64'd7, 1'b0, 1'b1);
        wait_grant(0, t);
        push(1'b0, 64'd2);
        tick();
        bus.ReqValid0 = 1'b0;
        wait_rsp(r);
        chk("lat_rsp_rem", XLEN'(r), XLEN'(CACHE ? t + 1 : t + 2 + N));
        chk("start_pulses_rem", XLEN'(start_cnt - s0), XLEN'(CACHE ? 0 : 1));
        wait_sb_empty();

        // Contention and round-robin alternation
        set_req(0, 1'b1, 64'd40, 64'd5, 1'b0, 1'b0);
        set_req(1, 1'b1, 64'd81, 64'd10, 1'b0, 1'b1);
        wait_grant_any(g, t);
        chk("rr_first_p0", XLEN'(g), 0);
        push(1'b0, 64'd8);
        tick();
        set_req(0, 1'b1, 64'd50, 64'd6, 1'b0, 1'b1);
        wait_grant_any(g, t);
        chk("rr_second_p1", XLEN'(g), 1);
        push(1'b1, 64'd1);
        tick();
        bus.ReqValid1 = 1'b0;
        wait_grant_any(g, t);
        chk("rr_third_p0", XLEN'(g), 0);
        push(1'b0, 64'd2);
        tick();
        bus.ReqValid0 = 1'b0;
        wait_sb_empty();

        // Backpressure: response held, no grants while in RESP
        bus.RspReady = 1'b0;
        set_req(1, 1'b1, 64'd200, 64'd9, 1'b0, 1'b0);
        wait_grant(1, t);
        push(1'b1, 64'd22);
        tick();
        bus.ReqValid1 = 1'b0;
        wait_rsp(r);
        tick();
        set_req(0, 1'b1, 64'd77, 64'd7, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", XLEN'(bus.RspValid), 1);
            chk("bp_data", bus.RspData, 64'd22);
            chk("bp_id", XLEN'(bus.RspId), 1);
            chk("bp_ready", XLEN'({bus.ReqReady1, bus.ReqReady0}), 0);
        end
        tick();
        bus.RspReady = 1'b1;
        wait_grant(0, t);
        push(1'b0, 64'd11);
        tick();
        bus.ReqValid0 = 1'b0;
        wait_sb_empty();

        // Flush of owner in WAIT: drained, next port-0 request completes
        set_req(1, 1'b1, 64'd300, 64'd7, 1'b0, 1'b0);
        wait_grant(1, t);
        tick();
        bus.ReqValid1 = 1'b0;
        repeat (3) tick();
        bus.Flush1 = 1'b1;
        fc = cyc;
        tick();
        bus.Flush1 = 1'b0;
        set_req(0, 1'b1, 64'd90, 64'd9, 1'b0, 1'b0);
        @(negedge clk);
        chk("drain_no_grant", XLEN'(bus.ReqReady0), 0);
        chk("drain_no_rsp", XLEN'(bus.RspValid), 0);
        wait_grant(0, t);
        chk("drain_exit", XLEN'(t), XLEN'(fc + 2));
        push(1'b0, 64'd10);
        tick();
        bus.ReqValid0 = 1'b0;
        wait_sb_empty();

        // Flush of non-owner has no effect
        set_req(1, 1'b1, 64'd65, 64'd8, 1'b0, 1'b1);
        wait_grant(1, t);
        push(1'b1, 64'd1);
        tick();
        bus.ReqValid1 = 1'b0;
        bus.Flush0 = 1'b1;
        repeat (3) tick();
        bus.Flush0 = 1'b0;
        wait_sb_empty();

        // Flush in RESP drops the response; flush in IDLE blocks that grant
        bus.RspReady = 1'b0;
        set_req(0, 1'b1, 64'd33, 64'd4, 1'b0, 1'b0);
        wait_grant(0, t);
        tick();
        bus.ReqValid0 = 1'b0;
        wait_rsp(r);
        tick();
        bus.Flush0 = 1'b1;
        tick();
        set_req(0, 1'b1, 64'd12, 64'd4, 1'b0, 1'b0);
        @(negedge clk);
        chk("resp_flush_drop", XLEN'(bus.RspValid), 0);
        chk("idle_flush_block", XLEN'(bus.ReqReady0), 0);
        tick();
        bus.Flush0 = 1'b0;
        bus.RspReady = 1'b1;
        wait_grant(0, t);
        push(1'b0, 64'd3);
        tick();
        bus.ReqValid0 = 1'b0;
        wait_sb_empty();

        // Reset mid-WAIT, then a signed divide
        set_req(0, 1'b1, 64'd1000, 64'd3, 1'b0, 1'b0);
        wait_grant(0, t);
        tick();
        bus.ReqValid0 = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        set_req(0, 1'b1, -64'sd20, 64'd3, 1'b1, 1'b0);
        @(negedge clk);
        chk("mid_rst_rspvalid", XLEN'(bus.RspValid), 0);
        chk("mid_rst_divstart", XLEN'(bus.DivStart), 0);
        chk("mid_rst_srca", bus.DivSrcA, 0);
        chk("mid_rst_idle_grant", XLEN'(bus.ReqReady0), 1);
        if (bus.ReqReady0) push(1'b0, -64'sd6);
        tick();
        bus.ReqValid0 = 1'b0;
        wait_sb_empty();

        set_req(0, 1'b1, -64'sd20, 64'd3, 1'b1, 1'b1);
        wait_grant(0, t);
        push(1'b0, -64'sd2);
        tick();
        bus.ReqValid0 = 1'b0;
        wait_sb_empty();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/div_arbiter.md
# div_arbiter

Two-port arbiter and sequencer that shares one iterative integer divider (the MDU restoring divider) between two requesters, for example the integer pipeline and a coprocessor or second hart. It registers the winning request, pulses the divider start, and waits for completion. It then returns the quotient or remainder on a valid/ready response channel tagged with the requester ID. Requester flushes are handled by draining and discarding in-flight results.

## Interface
- XLEN, 64, datapath width (32 or 64)
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- ReqValid0 / ReqValid1  in  1  request valid, port 0 / port 1
- ReqReady0 / ReqReady1  out  1  request accepted this cycle (grant)
- ReqSrcA0 / ReqSrcA1  in  XLEN  dividend
- ReqSrcB0 / ReqSrcB1  in  XLEN  divisor
- ReqSigned0 / ReqSigned1  in  1  signed operation
- ReqW640 / ReqW641  in  1  W-type (32-bit) operation; ignored (treated 0) when XLEN=32
- ReqRem0 / ReqRem1  in  1  return remainder (1) or quotient (0)
- Flush0 / Flush1  in  1  kill that requester's outstanding operation
- RspValid  out  1  response valid
- RspReady  in  1  response consumed
- RspId  out  1  requester owning the response
- RspData  out  XLEN  quotient or remainder
- DivStart  out  1  one-cycle start pulse to divider
- DivSrcA, DivSrcB  out  XLEN  registered operands, stable from DivStart until DivDone
- DivSigned, DivW64  out  1  registered controls, same stability rule
- DivDone  in  1  divider result valid this cycle
- DivQuot, DivRem  in  XLEN  divider results, sampled when DivDone=1

## Operation
- States: IDLE, ISSUE, WAIT, RESP, DRAIN.
- IDLE:
  - Grant goes to the single valid requester.
  - If both ports are valid, grant goes to the port selected by the round-robin pointer Prio.
  - ReqReadyN = (state==IDLE) & grantN. At most one ReqReady is high per cycle.
  - On acceptance, capture A, B, Signed, W64, Rem and Owner. Toggle Prio to the non-granted port, but only when both were valid.
  - Go to ISSUE.
- ISSUE: DivStart=1 for exactly one cycle, then WAIT.
- WAIT: on DivDone, capture DivQuot or DivRem according to Rem into RspData, then RESP.
- RESP:
  - RspValid=1 with RspId=Owner.
  - Data and ID hold stable until RspReady. On RspReady, go to IDLE.
  - Back-to-back acceptance is not allowed in the same cycle.
- Flush of the owner:
  - In ISSUE or WAIT without DivDone: go to DRAIN. DRAIN waits for DivDone, discards the result, then goes to IDLE.
  - In WAIT in the same cycle as DivDone: discard the result, go to IDLE.
  - In RESP: drop RspValid next cycle, go to IDLE.
  - In IDLE on the requesting port: suppresses that port's grant that cycle.
- Flush of the non-owner has no effect.
- Divide-by-zero and overflow semantics come entirely from the divider; the arbiter passes results through unmodified.

## Timing
- Reset values:
  - state=IDLE, Prio=0, Owner=0.
  - RspValid=0, DivStart=0, ReqReady0/1=0 during reset.
  - RspData, DivSrcA and DivSrcB are cleared to 0.
- Reset in mid-operation: the block returns to IDLE next cycle and any in-flight result is lost. The divider shares the same reset.
- Miss latency, with acceptance in cycle t:
  - DivStart in t+1.
  - DivDone in t+1+N, where N is the divider latency.
  - RspValid in t+2+N.
- ReqReady is combinational from ReqValid, Flush and state. No other output is combinational from inputs.
- DivDone seen outside WAIT or DRAIN is ignored.

## Configuration
- DIV_ARBITER_CACHE_EN
- When the macro is defined:
  - A one-entry result cache holds {valid, A, B, Signed, W64, Quot, Rem}.
  - The cache is written on every DivDone, including drained results.
  - A request accepted in IDLE hits when the cache is valid and A, B, Signed and W64 all match exactly; Rem is excluded from the match.
  - On a hit, the block skips ISSUE and WAIT and goes straight to RESP with the cached value, so RspValid appears in t+1.
  - Reset clears the valid bit.
- When the macro is undefined: there is no cache storage and every request takes the miss path.

## Test plan
- Single request: port 0, A=100, B=7, unsigned, Rem=0 -> one DivStart pulse; then RspValid with RspId=0 and RspData=14. Repeat with Rem=1 -> RspData=2.
- Contention: both ports valid with Prio=0 in cycle t -> ReqReady0=1 at t. Port 1 is granted at the next IDLE, and port 0 (re-requesting) is granted after that, confirming alternation.
- Backpressure: hold RspReady=0 for 5 cycles in RESP -> RspValid, RspData and RspId remain stable, and ReqReady0/1 stay 0 throughout.
- Flush in WAIT: Flush1 asserted 3 cycles after port 1's DivStart -> no response; DRAIN exits on DivDone and the next port 0 request completes correctly. Flush0 asserted while port 1 owns -> port 1's response is unaffected.
- Reset mid-WAIT: assert reset -> next cycle state=IDLE, RspValid=0, DivStart=0. A new request of A=-20, B=3, signed -> quotient -6, remainder -2.
- With DIV_ARBITER_CACHE_EN defined: request A=100, B=7, Rem=0, then A=100, B=7, Rem=1 -> the second request produces no DivStart and returns RspValid=1 with RspData=2 one cycle after acceptance.
